// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding and
// digit-counter sizing.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count digits 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells. It also
// exposes the carry into its MSB so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH/DIGIT clocks per add, LSB digit first, start/busy/done
// handshake; start is ignored while busy and the last result is held until the next one.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] addend,
  input  logic [WIDTH-1:0] augend,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic             dig_carry_msb;
  logic [WIDTH-1:0] acc_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .c_i     (carry_q),
    .s_o     (dig_sum),
    .c_o     (dig_carry),
    .c_msb_o (dig_carry_msb)
  );

  // New digit enters at the top; after N digits the LSB digit has reached bit 0.
  assign acc_shift = WIDTH'({dig_sum, acc_q} >> DIGIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = addend;
          b_d     = augend;
          acc_d   = '0;
          carry_d = carry_in;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dig_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_shift;
          cout_d  = dig_carry;
          ovf_d   = dig_carry ^ dig_carry_msb;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: several WIDTH/DIGIT instances share one stimulus stream
// and are checked against an arithmetic reference model plus directed tables.
module tb_serial_adder;

  localparam int NI  = 13;
  localparam int WIN = 34;
  localparam int CFG_W [NI] = '{8, 8, 8, 8, 16, 16, 16, 16, 32, 32, 32, 32, 1};
  localparam int CFG_D [NI] = '{1, 2, 4, 8, 1, 2, 4, 8, 1, 2, 4, 8, 1};
  localparam int I16_1 = 4;
  localparam int I16_4 = 6;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              start;
  logic [31:0]       addend;
  logic [31:0]       augend;
  logic              carry_in;
  logic [NI-1:0]     busy_w;
  logic [NI-1:0]     done_w;
  logic [NI-1:0]     co_w;
  logic [NI-1:0]     ov_w;
  logic [31:0]       sum_w [NI];

  int checks;
  int failures;

  logic [31:0] last_s    [NI];
  int          res_first [NI];
  int          res_cnt   [NI];
  logic [31:0] res_s     [NI];
  logic        res_co    [NI];
  logic        res_ov    [NI];
  bit          res_exp   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = CFG_W[gi];
    localparam int D = CFG_D[gi];
    logic [W-1:0] s;
    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .addend    (addend[W-1:0]),
      .augend    (augend[W-1:0]),
      .carry_in  (carry_in),
      .busy      (busy_w[gi]),
      .done      (done_w[gi]),
      .sum       (s),
      .carry_out (co_w[gi]),
      .overflow  (ov_w[gi])
    );
    assign sum_w[gi] = 32'(s);
  end

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain modulo arithmetic; overflow from operand/result sign rule.
  function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic c, output logic [31:0] s,
                                  output logic co, output logic ov);
    logic [32:0] m;
    logic [32:0] t;
    m  = (33'd1 << w) - 33'd1;
    t  = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c};
    s  = t[31:0] & m[31:0];
    co = t[w];
    ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic do_reset(input string tag);
    start     = 1'b1;
    sys_rst_n = 1'b0;
    #2;
    chk({tag, "_busy"}, 32'(busy_w), 32'd0);
    chk({tag, "_done"}, 32'(done_w), 32'd0);
    chk({tag, "_cout"}, 32'(co_w), 32'd0);
    chk({tag, "_ovf"},  32'(ov_w), 32'd0);
    for (int g = 0; g < NI; g++) chk($sformatf("%s_sum[%0d]", tag, g), sum_w[g], 32'd0);
    @(posedge sys_clk);
    #1;
    start     = 1'b0;
    sys_rst_n = 1'b1;
    for (int g = 0; g < NI; g++) last_s[g] = '0;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
      chk({tag, "_idle_busy"}, 32'(busy_w), 32'd0);
      chk({tag, "_idle_done"}, 32'(done_w), 32'd0);
    end
  endtask

  // One-cycle start pulse, then watch every instance for the full window.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [31:0] es;
    logic        eco, eov;
    for (int g = 0; g < NI; g++) begin
      res_first[g] = -1;
      res_cnt[g]   = 0;
      res_exp[g]   = 1'b0;
    end
    addend   = a;
    augend   = b;
    carry_in = c;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge sys_clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        if (done_w[g]) begin
          res_cnt[g]++;
          if (res_first[g] < 0) begin
            res_first[g] = k;
            res_s[g]     = sum_w[g];
            res_co[g]    = co_w[g];
            res_ov[g]    = ov_w[g];
          end
        end
        if (busy_w[g] && sum_w[g] !== last_s[g]) res_exp[g] = 1'b1;
      end
    end
    for (int g = 0; g < NI; g++) begin
      ref_add(CFG_W[g], a, b, c, es, eco, eov);
      chk($sformatf("latency[%0d]", g), res_first[g], CFG_W[g] / CFG_D[g]);
      chk($sformatf("done_pulses[%0d]", g), res_cnt[g], 1);
      chk($sformatf("sum[%0d]", g), res_s[g], es);
      chk($sformatf("cout[%0d]", g), 32'(res_co[g]), 32'(eco));
      chk($sformatf("ovf[%0d]", g), 32'(res_ov[g]), 32'(eov));
      chk($sformatf("partial_exposed[%0d]", g), 32'(res_exp[g]), 32'd0);
      last_s[g] = es;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [31:0] ra, rb, es;
    logic        rc, eco, eov;
    int          cnt1, cnt4, first1, first4, nd;
    logic [31:0] s1, s4;
    int          dk [8];
    logic [31:0] ds [8];

    checks    = 0;
    failures  = 0;
    sys_rst_n = 1'b1;
    start     = 1'b0;
    addend    = '0;
    augend    = '0;
    carry_in  = 1'b0;

    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vt[3] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

    #1;
    do_reset("rst");

    for (int i = 0; i < 4; i++) begin
      run_op(32'(vt[i].a), 32'(vt[i].b), vt[i].cin);
      chk($sformatf("tbl%0d_sum_d1", i), res_s[I16_1], 32'(vt[i].s));
      chk($sformatf("tbl%0d_cout_d1", i), 32'(res_co[I16_1]), 32'(vt[i].co));
      chk($sformatf("tbl%0d_ovf_d1", i), 32'(res_ov[I16_1]), 32'(vt[i].ov));
      chk($sformatf("tbl%0d_lat_d1", i), res_first[I16_1], 16);
      chk($sformatf("tbl%0d_sum_d4", i), res_s[I16_4], 32'(vt[i].s));
      chk($sformatf("tbl%0d_lat_d4", i), res_first[I16_4], 4);
    end

    // Start pulse and operand change while busy must not disturb the run.
    addend = 32'h0000ABCD; augend = 32'h00001111; carry_in = 1'b0; start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    cnt1 = 0; cnt4 = 0; first1 = -1; first4 = -1; s1 = '0; s4 = '0;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge sys_clk);
      #1;
      if (k == 2) begin
        start = 1'b1; addend = 32'h00000001; augend = 32'h00005555; carry_in = 1'b1;
      end
      if (k == 3) start = 1'b0;
      if (done_w[I16_1]) begin cnt1++; if (first1 < 0) begin first1 = k; s1 = sum_w[I16_1]; end end
      if (done_w[I16_4]) begin cnt4++; if (first4 < 0) begin first4 = k; s4 = sum_w[I16_4]; end end
    end
    chk("midrun_done_cnt_d1", cnt1, 1);
    chk("midrun_lat_d1", first1, 16);
    chk("midrun_sum_d1", s1, 32'h0000BCDE);
    chk("midrun_done_cnt_d4", cnt4, 1);
    chk("midrun_lat_d4", first4, 4);
    chk("midrun_sum_d4", s4, 32'h0000BCDE);
    do_reset("rst_after_midrun");

    // Reset at cycle 5 of a 16-cycle run.
    run_op(32'h00001234, 32'h00004321, 1'b1);
    addend = 32'h0000F00F; augend = 32'h00000FF0; carry_in = 1'b1; start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("pre_abort_busy_d1", 32'(busy_w[I16_1]), 32'd1);
    do_reset("rst_midop");
    nd = 0;
    repeat (20) begin
      @(posedge sys_clk);
      #1;
      if (done_w != '0) nd++;
    end
    chk("after_abort_no_done", nd, 0);
    run_op(32'h0000F00F, 32'h00000FF0, 1'b1);

    // Start held high: one result every N+1 cycles.
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
    addend = ra; augend = rb; carry_in = rc; start = 1'b1;
    @(posedge sys_clk);
    #1;
    nd = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge sys_clk);
      #1;
      if (done_w[I16_1] && nd < 8) begin
        dk[nd] = k;
        ds[nd] = sum_w[I16_1];
        nd++;
      end
    end
    start = 1'b0;
    ref_add(16, ra, rb, rc, es, eco, eov);
    chk("held_done_count", nd, 4);
    for (int i = 0; i < 4 && i < nd; i++) begin
      chk($sformatf("held_done_cycle%0d", i), dk[i], 16 + 17 * i);
      chk($sformatf("held_sum%0d", i), ds[i], es);
    end
    do_reset("rst_after_held");

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = ~ra;
        2: begin ra = 32'h7FFF_FFFF; rb = 32'h7FFF_FFFF; end
        default: ;
      endcase
      run_op(ra, rb, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
